// File: rtl/nios2_debug_scan_master_if.sv
// nios2_debug_scan_master_if: command/response handshake and virtual-JTAG pins of the scan master
interface nios2_debug_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  logic                cmd_valid, cmd_ready, cmd_skip_ir;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;
  logic                rsp_valid, rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic                vj_tck, vj_tdi, vj_tdo, vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti;
  logic [IR_WIDTH-1:0] vj_ir_in;
  modport master (
    input  cmd_valid, cmd_skip_ir, cmd_ir, cmd_data, rsp_ready, vj_tdo,
    output cmd_ready, rsp_valid, rsp_data, vj_tck, vj_tdi, vj_ir_in,
           vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti
  );
  modport slave (
    output cmd_valid, cmd_skip_ir, cmd_ir, cmd_data, rsp_ready, vj_tdo,
    input  cmd_ready, rsp_valid, rsp_data, vj_tck, vj_tdi, vj_ir_in,
           vj_uir, vj_cdr, vj_sdr, vj_udr, vj_rti
  );
endinterface

// File: rtl/nios2_debug_scan_master.sv
// nios2_debug_scan_master: drives one {ir, dr} scan into the Nios II debug slave and returns the captured DR
module nios2_debug_scan_master #(
  parameter int CLK_DIV  = 2,
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int RTI_TCKS = 2
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  nios2_debug_scan_master_if.master io_bus
);
  localparam int HW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DR_WIDTH + 1);
  localparam int RW = RTI_TCKS > 1 ? $clog2(RTI_TCKS) : 1;
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RTI, RSP} state_t;
  state_t              r_state, w_state_nxt;
  logic [HW-1:0]       r_half;
  logic [BW-1:0]       r_bits;
  logic [RW-1:0]       r_rti;
  logic [DR_WIDTH-1:0] r_shift, r_rsp_data;
  logic [IR_WIDTH-1:0] r_ir;
  logic                r_tck, r_tdo, r_rsp_valid;
  logic                w_active, w_half_end, w_period_end, w_rise, w_tdo, w_accept;
  assign w_active     = r_state != IDLE && r_state != RSP;
  assign w_half_end   = r_half == HW'(CLK_DIV - 1);
  assign w_period_end = w_active && r_tck && w_half_end;
  assign w_rise       = r_tck && r_half == '0;
  // with CLK_DIV=1 the rising-phase sample and the period end share one edge
  assign w_tdo        = w_rise ? io_bus.vj_tdo : r_tdo;
  assign w_accept     = io_bus.cmd_valid && io_bus.cmd_ready;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = w_accept ? (io_bus.cmd_skip_ir ? CDR : UIR) : IDLE;
      UIR:     w_state_nxt = w_period_end ? CDR : UIR;
      CDR:     w_state_nxt = w_period_end ? SDR : CDR;
      SDR:     w_state_nxt = w_period_end && r_bits == BW'(1) ? UDR : SDR;
      UDR:     w_state_nxt = w_period_end ? RTI : UDR;
      RTI:     w_state_nxt = w_period_end && r_rti == RW'(RTI_TCKS - 1) ? RSP : RTI;
      RSP:     w_state_nxt = r_rsp_valid && io_bus.rsp_ready ? IDLE : RSP;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_half      <= '0;
      r_bits      <= '0;
      r_rti       <= '0;
      r_shift     <= '0;
      r_rsp_data  <= '0;
      r_ir        <= '0;
      r_tck       <= 1'b0;
      r_tdo       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_shift <= io_bus.cmd_data;
        r_bits  <= BW'(DR_WIDTH);
        r_half  <= '0;
        r_tck   <= 1'b0;
        if (!io_bus.cmd_skip_ir) r_ir <= io_bus.cmd_ir;
      end else if (w_active) begin
        r_half <= w_half_end ? '0 : r_half + 1'b1;
        if (w_half_end) r_tck <= ~r_tck;
        if (w_rise) r_tdo <= io_bus.vj_tdo;
        if (w_period_end && r_state == SDR) begin
          r_shift <= {w_tdo, r_shift[DR_WIDTH-1:1]};
          r_bits  <= r_bits - 1'b1;
        end
        if (w_period_end) r_rti <= r_state == RTI ? r_rti + 1'b1 : '0;
      end
      // first RSP cycle publishes the captured word; it then waits for the consumer
      if (r_state == RSP && !r_rsp_valid) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= r_shift;
      end else if (r_rsp_valid && io_bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
  assign io_bus.cmd_ready = r_state == IDLE && !r_rsp_valid;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_data  = r_rsp_data;
  assign io_bus.vj_tck    = r_tck;
  assign io_bus.vj_tdi    = r_state == SDR ? r_shift[0] : 1'b0;
  assign io_bus.vj_ir_in  = r_ir;
  assign io_bus.vj_uir    = r_state == UIR;
  assign io_bus.vj_cdr    = r_state == CDR;
  assign io_bus.vj_sdr    = r_state == SDR;
  assign io_bus.vj_udr    = r_state == UDR;
  assign io_bus.vj_rti    = r_state == RTI;
endmodule

// File: tb/tb_nios2_debug_scan_master.sv
// tb_nios2_debug_scan_master: scoreboard bench for the scan master at CLK_DIV=2/RTI=2 and CLK_DIV=1/RTI=1
module tb_nios2_debug_scan_master;
  typedef struct {
    logic        sel;
    logic        skip;
    logic [1:0]  ir;
    logic [37:0] data;
    int          mode;
    logic [37:0] rsp;
    logic [1:0]  ir_after;
    int          lat;
    int          uirs;
  } vec_t;
  logic clk = 0, rst_n = 0, sel = 0, cv = 0, cskip = 0, rr = 0;
  logic [1:0]  cir = 0, rir, cur;
  logic [37:0] cdata = 0, held, rd, re;
  logic [37:0] tdi_seq = 0;
  logic [37:0] sb[$];
  logic h0 = 0, l0 = 0, h1 = 0, l1 = 0, ok, rk;
  int mode = 0, total = 0, bad = 0, uir_cnt = 0, sdr_cnt = 0, uir_base = 0, n, rm;
  vec_t v[6];
  logic o_ready, o_rsp_valid, o_tck, o_tdi, o_uir, o_cdr, o_sdr, o_udr, o_rti;
  logic [1:0]  o_ir;
  logic [37:0] o_rsp_data;
  always #5 clk = ~clk;
  nios2_debug_scan_master_if #(.DR_WIDTH(38), .IR_WIDTH(2)) b0 (), b1 ();
  nios2_debug_scan_master #(.CLK_DIV(2), .DR_WIDTH(38), .IR_WIDTH(2), .RTI_TCKS(2))
    u0 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b0));
  nios2_debug_scan_master #(.CLK_DIV(1), .DR_WIDTH(38), .IR_WIDTH(2), .RTI_TCKS(1))
    u1 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b1));
  assign b0.cmd_valid   = cv & ~sel;
  assign b1.cmd_valid   = cv & sel;
  assign b0.cmd_skip_ir = cskip;
  assign b1.cmd_skip_ir = cskip;
  assign b0.cmd_ir      = cir;
  assign b1.cmd_ir      = cir;
  assign b0.cmd_data    = cdata;
  assign b1.cmd_data    = cdata;
  assign b0.rsp_ready   = rr & ~sel;
  assign b1.rsp_ready   = rr & sel;
  // debug-slave stand-in: loopback returns the tdi of the previous tck period
  always @(posedge b0.vj_tck) begin l0 <= h0; h0 <= b0.vj_tdi; end
  always @(posedge b1.vj_tck) begin l1 <= h1; h1 <= b1.vj_tdi; end
  assign b0.vj_tdo = mode == 0 ? l0 : mode == 1;
  assign b1.vj_tdo = mode == 0 ? l1 : mode == 1;
  assign o_ready     = sel ? b1.cmd_ready : b0.cmd_ready;
  assign o_rsp_valid = sel ? b1.rsp_valid : b0.rsp_valid;
  assign o_rsp_data  = sel ? b1.rsp_data  : b0.rsp_data;
  assign o_tck       = sel ? b1.vj_tck    : b0.vj_tck;
  assign o_tdi       = sel ? b1.vj_tdi    : b0.vj_tdi;
  assign o_uir       = sel ? b1.vj_uir    : b0.vj_uir;
  assign o_cdr       = sel ? b1.vj_cdr    : b0.vj_cdr;
  assign o_sdr       = sel ? b1.vj_sdr    : b0.vj_sdr;
  assign o_udr       = sel ? b1.vj_udr    : b0.vj_udr;
  assign o_rti       = sel ? b1.vj_rti    : b0.vj_rti;
  assign o_ir        = sel ? b1.vj_ir_in  : b0.vj_ir_in;
  always @(posedge o_tck) begin
    if (o_uir) uir_cnt <= uir_cnt + 1;
    if (o_cdr) begin sdr_cnt <= 0; tdi_seq <= '0; end
    if (o_sdr) begin sdr_cnt <= sdr_cnt + 1; tdi_seq <= {o_tdi, tdi_seq[37:1]}; end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic send(input logic s, input logic k, input logic [1:0] ir, input logic [37:0] d,
                      input int m, input logic [37:0] e);
    int c = 0;
    @(negedge clk);
    sel = s; cskip = k; cir = ir; cdata = d; mode = m; cv = 1;
    while (!o_ready && c < 300) begin @(negedge clk); c++; end
    chk("ready_timeout", 64'(c >= 300), 0);
    uir_base = uir_cnt;
    sb.push_back(e);
    @(negedge clk);
    cv = 0;
    chk("busy_after_accept", o_ready, 0);
  endtask
  task automatic wait_rsp(input int lat, input logic [1:0] ir, input int uirs, input logic [37:0] d);
    int c = 0;
    logic [37:0] e;
    while (!o_rsp_valid && c < 400) begin @(negedge clk); c++; end
    chk("sb_depth", sb.size(), 1);
    e = sb.size() != 0 ? sb.pop_front() : 'x;
    chk("latency", c, lat);
    chk("rsp_data", o_rsp_data, e);
    chk("ir_in", o_ir, ir);
    chk("uir_periods", uir_cnt - uir_base, uirs);
    chk("sdr_periods", sdr_cnt, 38);
    chk("tdi_seq", tdi_seq, d);
  endtask
  task automatic ack();
    @(negedge clk); rr = 1;
    @(negedge clk); rr = 0;
    chk("rsp_drop", o_rsp_valid, 0);
    chk("ready_after_ack", o_ready, 1);
  endtask
  initial begin
    v[0] = '{1'b0, 1'b0, 2'b01, 38'h2A_5A5A_5A5A, 0, 38'h14_B4B4_B4B4, 2'b01, 173, 1};
    v[1] = '{1'b0, 1'b1, 2'b10, 38'h01_2345_6789, 0, 38'h02_468A_CF12, 2'b01, 169, 0};
    v[2] = '{1'b0, 1'b0, 2'b11, 38'h15_5555_5555, 1, 38'h3F_FFFF_FFFF, 2'b11, 173, 1};
    v[3] = '{1'b0, 1'b1, 2'b00, 38'h3F_FFFF_FFFF, 2, 38'h00_0000_0000, 2'b11, 169, 0};
    v[4] = '{1'b0, 1'b0, 2'b10, 38'h3F_FFFF_FFFF, 0, 38'h3F_FFFF_FFFE, 2'b10, 173, 1};
    v[5] = '{1'b1, 1'b0, 2'b01, 38'h2A_5A5A_5A5A, 0, 38'h14_B4B4_B4B4, 2'b01, 85, 1};
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("reset_vj", {o_tck, o_tdi, o_uir, o_cdr, o_sdr, o_udr, o_rti, o_ir}, 0);
    chk("reset_ready", o_ready, 1);
    chk("reset_rsp_valid", o_rsp_valid, 0);
    chk("reset_rsp_data", o_rsp_data, 0);
    // reset in the middle of the shift
    cskip = 0; cir = 2'b11; cdata = 38'h2A_5A5A_5A5A; mode = 0; cv = 1;
    @(negedge clk);
    cv = 0;
    n = 0;
    while (sdr_cnt < 17 && n < 1000) begin @(negedge clk); n++; end
    chk("t1_bit17", sdr_cnt, 17);
    chk("t1_in_sdr", o_sdr, 1);
    chk("t1_ir_loaded", o_ir, 2'b11);
    #2 rst_n = 0;
    #1 chk("t1_vj_async", {o_tck, o_tdi, o_uir, o_cdr, o_sdr, o_udr, o_rti, o_ir}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("t1_ready", o_ready, 1);
    ok = 1;
    for (int i = 0; i < 200; i++) begin @(negedge clk); if (o_rsp_valid) ok = 0; end
    chk("t1_no_rsp", ok, 1);
    for (int i = 0; i < 6; i++) begin
      send(v[i].sel, v[i].skip, v[i].ir, v[i].data, v[i].mode, v[i].rsp);
      wait_rsp(v[i].lat, v[i].ir_after, v[i].uirs, v[i].data);
      ack();
    end
    // response backpressure with the next command already waiting
    send(0, 0, 2'b01, 38'h0F_0F0F_0F0F, 1, 38'h3F_FFFF_FFFF);
    wait_rsp(173, 2'b01, 1, 38'h0F_0F0F_0F0F);
    cskip = 1; cir = 2'b10; cdata = 38'h00_0000_00FF; mode = 0; cv = 1;
    held = o_rsp_data;
    ok = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (o_rsp_data !== held || !o_rsp_valid || o_ready || o_tck) ok = 0;
    end
    chk("t5_stall", ok, 1);
    rr = 1;
    @(negedge clk);
    rr = 0;
    chk("t5_ready_next", o_ready, 1);
    chk("t5_rsp_drop", o_rsp_valid, 0);
    uir_base = uir_cnt;
    sb.push_back(38'h00_0000_01FE);
    @(negedge clk);
    cv = 0;
    chk("t5_accepted", o_ready, 0);
    chk("t5_cdr", o_cdr, 1);
    wait_rsp(169, 2'b01, 0, 38'h00_0000_00FF);
    ack();
    // random scans on the fastest configuration against the bench model
    cur = 2'b01;
    for (int i = 0; i < 100; i++) begin
      rk  = 1'($urandom);
      rir = 2'($urandom);
      rd  = {6'($urandom), 32'($urandom)};
      rm  = int'($urandom_range(0, 2));
      re  = rm == 0 ? {rd[36:0], 1'b0} : rm == 1 ? 38'h3F_FFFF_FFFF : 38'h0;
      if (!rk) cur = rir;
      send(1, rk, rir, rd, rm, re);
      wait_rsp(((rk ? 2 : 3) + 39) * 2 + 1, cur, rk ? 0 : 1, rd);
      ack();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
